// File: rtl/pipe_stage_chain.sv
// Depth-generic pipeline register chain with per-stage stall/flush, bubble insertion,
// youngest-match forwarding lookup, occupancy count and a saturating stall-cycle counter.
module pipe_stage_chain #(
   parameter int STAGES = 4,
   parameter int DW     = 32,
   parameter int RW     = 5,
   parameter int SW     = 2,
   parameter int CW     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DW-1:0]     in_data,
   input  logic              in_wr,
   input  logic [RW-1:0]     in_dst,
   output logic              in_ready,
   input  logic [STAGES-1:0] stall,
   input  logic [STAGES-1:0] flush,
   output logic              out_valid,
   output logic [DW-1:0]     out_data,
   output logic              out_wr,
   output logic [RW-1:0]     out_dst,
   input  logic [RW-1:0]     q_reg,
   output logic              q_hit,
   output logic [SW-1:0]     q_stage,
   output logic [DW-1:0]     q_data,
   output logic [SW:0]       occ,
   output logic [CW-1:0]     stall_cnt
);

   logic [STAGES-1:0] valid_reg;
   logic [STAGES-1:0] wr_reg;
   logic [DW-1:0]     data_reg [STAGES];
   logic [RW-1:0]     dst_reg  [STAGES];
   logic [STAGES-1:0] hold;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         // A stage holds whenever it or any older stage is stalled.
         assign hold[gi] = |stall[STAGES-1:gi];

         if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  valid_reg[gi] <= 1'b0;
                  wr_reg[gi]    <= 1'b0;
                  data_reg[gi]  <= '0;
                  dst_reg[gi]   <= '0;
               end else if (flush[gi] || (!hold[gi] && !in_valid)) begin
                  valid_reg[gi] <= 1'b0;
                  wr_reg[gi]    <= 1'b0;
                  data_reg[gi]  <= '0;
                  dst_reg[gi]   <= '0;
               end else if (!hold[gi]) begin
                  valid_reg[gi] <= 1'b1;
                  wr_reg[gi]    <= in_wr;
                  data_reg[gi]  <= in_data;
                  dst_reg[gi]   <= in_dst;
               end
            end
         end else begin : g_body
            // The younger neighbour being held means it cannot advance: insert a bubble.
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  valid_reg[gi] <= 1'b0;
                  wr_reg[gi]    <= 1'b0;
                  data_reg[gi]  <= '0;
                  dst_reg[gi]   <= '0;
               end else if (flush[gi] || (!hold[gi] && hold[gi-1])) begin
                  valid_reg[gi] <= 1'b0;
                  wr_reg[gi]    <= 1'b0;
                  data_reg[gi]  <= '0;
                  dst_reg[gi]   <= '0;
               end else if (!hold[gi]) begin
                  valid_reg[gi] <= valid_reg[gi-1];
                  wr_reg[gi]    <= wr_reg[gi-1];
                  data_reg[gi]  <= data_reg[gi-1];
                  dst_reg[gi]   <= dst_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   assign in_ready  = !hold[0];
   assign out_valid = valid_reg[STAGES-1];
   assign out_data  = data_reg[STAGES-1];
   assign out_wr    = wr_reg[STAGES-1] & valid_reg[STAGES-1];
   assign out_dst   = dst_reg[STAGES-1];

   // Scan oldest to youngest so the youngest candidate is the last one written.
   always_comb begin
      q_hit   = 1'b0;
      q_stage = '0;
      q_data  = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         if (valid_reg[i] && wr_reg[i] && (dst_reg[i] == q_reg) && (q_reg != '0)) begin
            q_hit   = 1'b1;
            q_stage = SW'(i);
            q_data  = data_reg[i];
         end
      end
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ = occ + {{SW{1'b0}}, valid_reg[i]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if ((|stall) && (stall_cnt != {CW{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Randomised and directed bench for pipe_stage_chain against a per-stage rule model.
module tb_pipe_stage_chain;
   localparam int S  = 4;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int SW = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_wr = 1'b0;
   logic [RW-1:0] in_dst = '0;
   logic          in_ready;
   logic [S-1:0]  stall = '0;
   logic [S-1:0]  flush = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_wr;
   logic [RW-1:0] out_dst;
   logic [RW-1:0] q_reg = '0;
   logic          q_hit;
   logic [SW-1:0] q_stage;
   logic [DW-1:0] q_data;
   logic [SW:0]   occ;
   logic [CW-1:0] stall_cnt;

   pipe_stage_chain #(.STAGES(S), .DW(DW), .RW(RW), .SW(SW), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_wr(in_wr), .in_dst(in_dst),
      .in_ready(in_ready), .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_data(out_data), .out_wr(out_wr), .out_dst(out_dst),
      .q_reg(q_reg), .q_hit(q_hit), .q_stage(q_stage), .q_data(q_data),
      .occ(occ), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   bit            m_valid [S];
   bit            m_wr    [S];
   logic [DW-1:0] m_data  [S];
   logic [RW-1:0] m_dst   [S];
   int            m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < S; i++) begin
         m_valid[i] = 0; m_wr[i] = 0; m_data[i] = '0; m_dst[i] = '0;
      end
      m_cnt = 0;
   endtask

   task automatic check_all();
      int occ_e = 0;
      bit hit = 0;
      int qs = 0;
      logic [31:0] qd = '0;
      for (int i = 0; i < S; i++) begin
         occ_e += int'(m_valid[i]);
         if (!hit && m_valid[i] && m_wr[i] && m_dst[i] == q_reg && q_reg != 0) begin
            hit = 1; qs = i; qd = m_data[i];
         end
      end
      chk("out_valid", out_valid, m_valid[S-1]);
      chk("out_data",  out_data,  m_data[S-1]);
      chk("out_wr",    out_wr,    m_wr[S-1] & m_valid[S-1]);
      chk("out_dst",   out_dst,   m_dst[S-1]);
      chk("in_ready",  in_ready,  stall == 0);
      chk("occ",       occ,       occ_e);
      chk("q_hit",     q_hit,     hit);
      chk("q_stage",   q_stage,   qs);
      chk("q_data",    q_data,    qd);
      chk("stall_cnt", stall_cnt, m_cnt);
   endtask

   // Applies the stage update rules to the pre-edge snapshot.
   task automatic model_update();
      bit            pv [S];
      bit            pw [S];
      logic [DW-1:0] pd [S];
      logic [RW-1:0] pr [S];
      pv = m_valid; pw = m_wr; pd = m_data; pr = m_dst;
      for (int i = 0; i < S; i++) begin
         bit held = (stall >> i) != 0;
         bit kill;
         if (flush[i]) kill = 1;
         else if (held) kill = 0;
         else if (i == 0) kill = !in_valid;
         else kill = stall[i-1];
         if (kill) begin
            m_valid[i] = 0; m_wr[i] = 0; m_data[i] = '0; m_dst[i] = '0;
         end else if (!held) begin
            if (i == 0) begin
               m_valid[i] = 1; m_wr[i] = in_wr; m_data[i] = in_data; m_dst[i] = in_dst;
            end else begin
               m_valid[i] = pv[i-1]; m_wr[i] = pw[i-1]; m_data[i] = pd[i-1]; m_dst[i] = pr[i-1];
            end
         end
      end
      if (stall != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
   endtask

   task automatic apply(input bit iv, input logic [DW-1:0] id, input bit iw,
                        input logic [RW-1:0] idst, input logic [S-1:0] st,
                        input logic [S-1:0] fl, input logic [RW-1:0] q);
      in_valid = iv; in_data = id; in_wr = iw; in_dst = idst;
      stall = st; flush = fl; q_reg = q;
   endtask

   task automatic step();
      #1;
      check_all();
      model_update();
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_clear();
      #12;
      check_all();
      reset = 1'b1;
      @(posedge clk); #1;

      // Fill with 1..4, one stall cycle, then asynchronous reset mid-cycle.
      for (int k = 1; k <= 4; k++) begin
         apply(1, DW'(k), 1, RW'(k), '0, '0, '0);
         step();
      end
      chk("fill_occ", occ, 4);
      apply(0, '0, 0, '0, 4'b1000, '0, 5'd2);
      step();
      chk("fill_cnt", stall_cnt, 1);
      apply(0, '0, 0, '0, '0, '0, 5'd2);
      #2;
      reset = 1'b0;
      #1;
      model_clear();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_occ", occ, 0);
      chk("rst_cnt", stall_cnt, 0);
      check_all();
      #2;
      reset = 1'b1;
      @(posedge clk); #1;

      // Straight flow A0..A5.
      for (int k = 0; k < 6; k++) begin
         apply(1, 32'hA0 + DW'(k), 0, '0, '0, '0, '0);
         step();
         if (k == 3) chk("latency", out_data, 32'hA0);
      end
      chk("flow_occ", occ, 4);

      // Stall stage 2 for two cycles: stage 3 receives bubbles.
      for (int k = 0; k < 2; k++) begin
         apply(1, 32'hA6, 0, '0, 4'b0100, '0, '0);
         #1;
         chk("stall_ready", in_ready, 0);
         step();
         chk("stall_bubble", out_valid, 0);
      end
      chk("stall_cnt2", stall_cnt, 2);
      for (int k = 0; k < 4; k++) begin
         apply(1, 32'hA6 + DW'(k), 0, '0, '0, '0, '0);
         step();
      end

      // Flush stages 0,1 while stage 3 stalls.
      apply(1, 32'hBB, 0, '0, 4'b1000, 4'b0011, '0);
      step();
      chk("flush_occ", occ, 2);

      // Forwarding: stage1 dst 8 (wr varies), stage3 dst 8 wr=1.
      for (int pass = 0; pass < 2; pass++) begin
         apply(1, 32'h33, 1, 5'd8, '0, '0, '0); step();
         apply(1, 32'h22, 1, 5'd3, '0, '0, '0); step();
         apply(1, 32'h11, pass == 0, 5'd8, '0, '0, '0); step();
         apply(0, '0, 0, '0, '0, '0, '0); step();
         apply(0, '0, 0, '0, 4'b1000, '0, 5'd8);
         #1;
         chk("fwd_hit", q_hit, 1);
         chk("fwd_stage", q_stage, pass == 0 ? 1 : 3);
         chk("fwd_data", q_data, pass == 0 ? 32'h11 : 32'h33);
         q_reg = '0;
         #1;
         chk("fwd_zero", q_hit, 0);
         q_reg = 5'd8;
         step();
      end

      // Saturation: 20 stall cycles with CW=4.
      for (int k = 0; k < 20; k++) begin
         apply(1, 32'hC0, 0, '0, 4'b0001, '0, '0);
         step();
      end
      chk("sat_cnt", stall_cnt, 15);

      // Randomised traffic.
      for (int k = 0; k < 400; k++) begin
         logic [S-1:0] st = '0;
         logic [S-1:0] fl = '0;
         for (int i = 0; i < S; i++) begin
            st[i] = ($urandom_range(0, 7) == 0);
            fl[i] = ($urandom_range(0, 15) == 0);
         end
         apply($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
               RW'($urandom_range(0, 3)), st, fl, RW'($urandom_range(0, 3)));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised, depth-generic replacement for hand-instantiated per-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB style).
- Carries a payload plus register-write tag through STAGES stages.
- Supports per-stage stall with automatic bubble insertion and per-stage flush.
- Provides a combinational youngest-match forwarding query over all in-flight stages, plus a stall-cycle counter for profiling.

Parameters:
- STAGES, 4, number of pipeline stages (>=2); stage 0 is youngest, stage STAGES-1 drives outputs.
- DW, 32, payload width.
- RW, 5, destination register index width; index 0 is never a forwarding source.
- SW, 2, width of q_stage; must satisfy 2**SW >= STAGES.
- CW, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  new entry offered to stage 0.
- in_data  in  DW  payload.
- in_wr  in  1  entry writes a register.
- in_dst  in  RW  destination register.
- in_ready  out  1  stage 0 accepts this cycle.
- stall  in  STAGES  per-stage hold request.
- flush  in  STAGES  per-stage kill.
- out_valid  out  1  stage STAGES-1 valid.
- out_data  out  DW  stage STAGES-1 payload.
- out_wr  out  1  stage STAGES-1 write flag (already ANDed with valid).
- out_dst  out  RW  stage STAGES-1 destination.
- q_reg  in  RW  forwarding query register.
- q_hit  out  1  match found.
- q_stage  out  SW  stage index of the match.
- q_data  out  DW  payload of the match.
- occ  out  SW+1  count of valid stages.
- stall_cnt  out  CW  saturating count of cycles with any stall bit set.

Behaviour:
- Reset (reset=0, asynchronous):
  - all stage valid, wr, dst, data <= 0; stall_cnt <= 0.
  - Hence out_* = 0, occ = 0, q_hit = 0, q_stage = 0, q_data = 0.
  - Release is synchronous to clk. An in-flight entry at reset assertion is discarded.
- Hold: h[i] = OR(stall[j]) for j >= i. A stall in a later stage freezes all younger stages.
- in_ready = !h[0]. An entry is accepted when in_valid & in_ready. While in_ready=0, in_* are ignored and upstream must re-present them.
- Per-stage update each clock, evaluated in priority order:
  1. flush[i]=1: valid[i] <= 0, wr[i] <= 0, data/dst <= 0. Flush overrides hold and stall.
  2. else h[i]=1: stage i holds all fields.
  3. else i=0: stage 0 loads in_* if in_valid; otherwise it loads a bubble (valid=0, wr=0, data=0, dst=0).
  4. else h[i-1]=1 (only possible when stall[i-1]=1): stage i loads a bubble.
  5. else: stage i loads stage i-1's fields.
- Latency: an entry accepted at edge N appears on out_* after edge N+STAGES-1 when there are no stalls. Each stall cycle on its path adds 1 cycle.
- Outputs out_* are registered and equal stage STAGES-1 fields. out_wr = wr[S-1] & valid[S-1].
- Forwarding query (combinational):
  - Candidate stage i: valid[i] & wr[i] & dst[i]==q_reg & q_reg!=0.
  - The lowest candidate index (youngest) wins. q_hit=1, q_stage=i, q_data=data[i].
  - With no candidate: q_hit=0, q_stage=0, q_data=0.
  - Stages flushed or bubbled this cycle still report their current (pre-edge) contents.
- occ: combinational popcount of valid[].
- stall_cnt: increments by 1 on each edge where |stall is 1. It saturates at 2**CW-1 and never wraps.
- Simultaneous stall[i] and flush[i]: stage i is cleared, and stages < i still hold.
- flush of all stages with in_valid=1 and in_ready=1: stage 0 is cleared; the input is consumed and lost. Upstream pairs flush[0] with its own redirect.
- stall[S-1]=1: out_* is held; the consumer must not double-count it, using its own valid/stall knowledge.

Test Plan:
- Reset mid-stream: fill 4 stages with data 1..4, assert reset=0 asynchronously -> all outputs 0 immediately, occ=0, stall_cnt=0.
- Straight flow, STAGES=4: in data 0xA0..0xA5 on consecutive cycles -> out_data 0xA0 three edges after acceptance, then one per cycle, out_valid continuous, occ=4 at steady state.
- Stall stage 2 for 2 cycles with full pipe -> stages 0..2 frozen, in_ready=0, stage 3 receives 2 bubbles (out_valid=0 for 2 cycles), no data lost or duplicated, stall_cnt=2.
- Flush stages 0,1 while stall[3]=1 -> stages 0,1 valid=0 next cycle, stage 2 holds, stage 3 holds, occ=2.
- Forwarding: stage1 (wr=1, dst=8, data=0x11) and stage3 (wr=1, dst=8, data=0x33), q_reg=8 -> q_hit=1, q_stage=1, q_data=0x11. Same with q_reg=0 -> q_hit=0. Same with stage1 wr=0 -> q_stage=3, q_data=0x33.
- Counter saturation with CW=4: stall held for 20 cycles -> stall_cnt stops at 15.
